// File: rtl/cpc_video_pkg.sv
// Shared CPC video types: screen modes, border pen index and the hardware-colour gun table.
package cpc_video_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } cpc_mode_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } gun_lvl_t;

  localparam logic [4:0] BORDER_PEN = 5'd16;
  localparam logic [4:0] BLACK_HW   = 5'h14;

  // Per hardware colour {r,g,b}, each gun 0 = off, 1 = half, 2 = full.
  localparam logic [5:0] HW_LEVELS [32] = '{
    6'h15, 6'h15, 6'h09, 6'h29, 6'h01, 6'h21, 6'h05, 6'h25,  // 0x00-0x07
    6'h21, 6'h29, 6'h28, 6'h2A, 6'h20, 6'h22, 6'h24, 6'h26,  // 0x08-0x0F
    6'h01, 6'h09, 6'h08, 6'h0A, 6'h00, 6'h02, 6'h04, 6'h06,  // 0x10-0x17
    6'h11, 6'h19, 6'h18, 6'h1A, 6'h10, 6'h12, 6'h14, 6'h16   // 0x18-0x1F
  };

  function automatic gun_lvl_t hw_colour_levels(input logic [4:0] hw);
    return gun_lvl_t'(HW_LEVELS[hw]);
  endfunction

  function automatic logic [1:0] level_to_code(input logic [1:0] lvl, input logic [1:0] half);
    logic [1:0] code;
    code = 2'd0;
    if (lvl == 2'd1) code = half;
    else if (lvl == 2'd2) code = 2'd3;
    return code;
  endfunction

endpackage

// File: rtl/cpc_pen_decode.sv
// Combinational pen extraction from the latched video byte for the current pixel sub-index.
module cpc_pen_decode
  import cpc_video_pkg::*;
(
  input  logic [7:0] i_byte,
  input  cpc_mode_e  i_mode,
  input  logic [2:0] i_sub,
  output logic [3:0] o_pen
);

  logic [2:0] w_shamt;
  logic [7:0] w_sh;

  // Shifting left by the pixel number within the byte brings that pixel's bits to b7/b3/b5/b1.
  always_comb begin
    w_shamt = 3'd0;
    o_pen   = 4'd0;
    unique case (i_mode)
      MODE2:        w_shamt = i_sub;
      MODE1:        w_shamt = {1'b0, i_sub[2:1]};
      MODE0, MODE3: w_shamt = {2'b00, i_sub[2]};
    endcase
    w_sh = i_byte << w_shamt;
    unique case (i_mode)
      MODE2:        o_pen = {3'b000, w_sh[7]};
      MODE1, MODE3: o_pen = {2'b00, w_sh[3], w_sh[7]};
      MODE0:        o_pen = {w_sh[1], w_sh[5], w_sh[3], w_sh[7]};
    endcase
  end

endmodule

// File: rtl/cpc_pixel_gen.sv
// Gate-array pixel stage: byte serialiser, palette lookup and 2-stage pipeline to R/G/B + timing.
module cpc_pixel_gen
  import cpc_video_pkg::*;
#(
  parameter logic [1:0] DEFAULT_MODE = 2'd1,
  parameter logic [1:0] HALF_LEVEL   = 2'd2
) (
  input  logic       clk_vid,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [7:0] byte_data,
  output logic       byte_ack,
  input  logic       de_in,
  input  logic       HSync_in,
  input  logic       VSync_in,
  input  logic       HBlank_in,
  input  logic       VBlank_in,
  input  logic       pal_we,
  input  logic [4:0] pal_addr,
  input  logic [4:0] pal_data,
  input  logic       mode_we,
  input  logic [1:0] mode_data,
  output logic [1:0] R_out,
  output logic [1:0] G_out,
  output logic [1:0] B_out,
  output logic       HSync_out,
  output logic       VSync_out,
  output logic       HBlank_out,
  output logic       VBlank_out
);

  logic [2:0] r_phase;
  logic       r_hs_prev;
  logic [7:0] r_shift;
  cpc_mode_e  r_mode;
  cpc_mode_e  r_mode_pend;
  logic [3:0] r_pen1;
  logic       r_de1;
  logic [3:0] r_tim1;
  logic [3:0] r_tim2;
  logic [1:0] r_r;
  logic [1:0] r_g;
  logic [1:0] r_b;
  logic [4:0] r_palette [17];

  logic       w_hs_rise;
  logic       w_load;
  logic [3:0] w_pen;
  logic [4:0] w_pen2;
  logic [4:0] w_hw;
  gun_lvl_t   w_lvl;

  assign w_hs_rise = HSync_in & ~r_hs_prev;
  assign w_load    = ce_pix & (r_phase == 3'd7);
  assign byte_ack  = w_load & ~reset;

  cpc_pen_decode u_pen_decode (
    .i_byte (r_shift),
    .i_mode (r_mode),
    .i_sub  (r_phase),
    .o_pen  (w_pen)
  );

  assign w_pen2 = r_de1 ? {1'b0, r_pen1} : BORDER_PEN;
  assign w_hw   = r_palette[w_pen2];
  assign w_lvl  = hw_colour_levels(w_hw);

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_phase     <= 3'd0;
      r_hs_prev   <= 1'b0;
      r_shift     <= 8'd0;
      r_mode      <= cpc_mode_e'(DEFAULT_MODE);
      r_mode_pend <= cpc_mode_e'(DEFAULT_MODE);
    end else begin
      if (mode_we) r_mode_pend <= cpc_mode_e'(mode_data);
      if (ce_pix) begin
        r_hs_prev <= HSync_in;
        r_phase   <= w_hs_rise ? 3'd0 : r_phase + 3'd1;
        // Mode switches only at line start so a line never mixes decodings.
        if (w_hs_rise) r_mode <= r_mode_pend;
        if (w_load) r_shift <= byte_data;
      end
    end
  end

  always_ff @(posedge clk_vid) begin
    if (reset) begin
      r_pen1 <= 4'd0;
      r_de1  <= 1'b0;
      r_tim1 <= 4'd0;
      r_tim2 <= 4'd0;
      r_r    <= 2'd0;
      r_g    <= 2'd0;
      r_b    <= 2'd0;
    end else if (ce_pix) begin
      r_pen1 <= w_pen;
      r_de1  <= de_in;
      r_tim1 <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
      r_tim2 <= r_tim1;
      r_r    <= level_to_code(w_lvl.r, HALF_LEVEL);
      r_g    <= level_to_code(w_lvl.g, HALF_LEVEL);
      r_b    <= level_to_code(w_lvl.b, HALF_LEVEL);
    end
  end

  // Palette writes are not gated by ce_pix; a same-clock lookup still sees the old entry.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      for (int i = 0; i < 17; i++) r_palette[i] <= BLACK_HW;
    end else if (pal_we && (pal_addr <= BORDER_PEN)) begin
      r_palette[pal_addr] <= pal_data;
    end
  end

  assign R_out      = r_r;
  assign G_out      = r_g;
  assign B_out      = r_b;
  assign HSync_out  = r_tim2[3];
  assign VSync_out  = r_tim2[2];
  assign HBlank_out = r_tim2[1];
  assign VBlank_out = r_tim2[0];

endmodule

// File: tb/tb_cpc_pixel_gen.sv
// Self-checking bench for cpc_pixel_gen: directed scenarios with literal expectations, then
// randomized traffic compared every clock against a tick-level behavioural model.
module tb_cpc_pixel_gen;

  localparam int Half = 2;

  logic       clk_vid = 1'b0;
  logic       reset, ce_pix, de_in;
  logic       HSync_in, VSync_in, HBlank_in, VBlank_in;
  logic [7:0] byte_data;
  logic       byte_ack;
  logic       pal_we, mode_we;
  logic [4:0] pal_addr, pal_data;
  logic [1:0] mode_data;
  logic [1:0] R_out, G_out, B_out;
  logic       HSync_out, VSync_out, HBlank_out, VBlank_out;

  always #5 clk_vid = ~clk_vid;

  cpc_pixel_gen #(
    .DEFAULT_MODE (2'd1),
    .HALF_LEVEL   (2'd2)
  ) dut (
    .clk_vid    (clk_vid),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .byte_data  (byte_data),
    .byte_ack   (byte_ack),
    .de_in      (de_in),
    .HSync_in   (HSync_in),
    .VSync_in   (VSync_in),
    .HBlank_in  (HBlank_in),
    .VBlank_in  (VBlank_in),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .mode_we    (mode_we),
    .mode_data  (mode_data),
    .R_out      (R_out),
    .G_out      (G_out),
    .B_out      (B_out),
    .HSync_out  (HSync_out),
    .VSync_out  (VSync_out),
    .HBlank_out (HBlank_out),
    .VBlank_out (VBlank_out)
  );

  int n_total = 0;
  int n_bad = 0;
  logic last_ack;

  // Hardware colour -> decimal digits r,g,b (0 off, 1 half, 2 full).
  int lut3 [32] = '{111, 111, 21, 221, 1, 201, 11, 211, 201, 221, 220, 222, 200, 202, 210, 212,
                    1, 21, 20, 22, 0, 2, 10, 12, 101, 121, 120, 122, 100, 102, 110, 112};

  int m_phase, m_hs_prev, m_byte, m_mode, m_pend;
  int m_pal [17];
  int s1_pen, s1_de, s1_tim;
  int e_r, e_g, e_b, e_tim;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lvl_code(input int l);
    return (l == 0) ? 0 : (l == 1) ? Half : 3;
  endfunction

  // Pixel px of a byte owns bits (7-px),(3-px),(5-px),(1-px) once the byte is shifted by px.
  function automatic int pen_of(input int b, input int mode, input int ph);
    int tpp, px, sh;
    tpp = (mode == 2) ? 1 : (mode == 1) ? 2 : 4;
    px  = ph / tpp;
    sh  = (b << px) & 255;
    if (mode == 2) return (sh >> 7) & 1;
    if (mode == 0)
      return ((sh >> 7) & 1) | (((sh >> 3) & 1) << 1) | (((sh >> 5) & 1) << 2) |
             (((sh >> 1) & 1) << 3);
    return ((sh >> 7) & 1) | (((sh >> 3) & 1) << 1);
  endfunction

  task automatic model_step();
    int pe, hw, rise;
    if (reset) begin
      m_phase = 0; m_hs_prev = 0; m_byte = 0; m_mode = 1; m_pend = 1;
      for (int i = 0; i < 17; i++) m_pal[i] = 'h14;
      s1_pen = 0; s1_de = 0; s1_tim = 0;
      e_r = 0; e_g = 0; e_b = 0; e_tim = 0;
    end else begin
      if (ce_pix) begin
        pe    = (s1_de != 0) ? s1_pen : 16;
        hw    = m_pal[pe];
        e_r   = lvl_code(lut3[hw] / 100);
        e_g   = lvl_code((lut3[hw] / 10) % 10);
        e_b   = lvl_code(lut3[hw] % 10);
        e_tim = s1_tim;
        s1_pen = pen_of(m_byte, m_mode, m_phase);
        s1_de  = int'(de_in);
        s1_tim = int'({HSync_in, VSync_in, HBlank_in, VBlank_in});
        rise = (HSync_in && m_hs_prev == 0) ? 1 : 0;
        m_hs_prev = int'(HSync_in);
        if (m_phase == 7) m_byte = int'(byte_data);
        if (rise != 0) begin
          m_mode  = m_pend;
          m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % 8;
        end
      end
      if (mode_we) m_pend = int'(mode_data);
      if (pal_we && pal_addr <= 5'd16) m_pal[pal_addr] = int'(pal_data);
    end
  endtask

  task automatic cyc();
    #1;
    last_ack = byte_ack;
    chk("byte_ack", int'(byte_ack), (ce_pix && !reset && m_phase == 7) ? 1 : 0);
    @(posedge clk_vid);
    model_step();
    @(negedge clk_vid);
    chk("R_out", int'(R_out), e_r);
    chk("G_out", int'(G_out), e_g);
    chk("B_out", int'(B_out), e_b);
    chk("HSync_out", int'(HSync_out), (e_tim >> 3) & 1);
    chk("VSync_out", int'(VSync_out), (e_tim >> 2) & 1);
    chk("HBlank_out", int'(HBlank_out), (e_tim >> 1) & 1);
    chk("VBlank_out", int'(VBlank_out), e_tim & 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pal(input int a, input int d);
    pal_we = 1'b1; pal_addr = 5'(a); pal_data = 5'(d);
    cyc();
    pal_we = 1'b0;
  endtask

  task automatic set_mode(input int m);
    mode_we = 1'b1; mode_data = 2'(m);
    cyc();
    mode_we = 1'b0;
  endtask

  task automatic hs_pulse();
    HSync_in = 1'b1;
    cyc();
    HSync_in = 1'b0;
  endtask

  task automatic chk_rgb(input string name, input int r, input int g, input int b);
    chk({name, "_R"}, int'(R_out), r);
    chk({name, "_G"}, int'(G_out), g);
    chk({name, "_B"}, int'(B_out), b);
  endtask

  initial begin
    int cnt_a, cnt_b, ack_n;
    reset = 1'b1; ce_pix = 1'b1; de_in = 1'b1; byte_data = 8'hFF;
    HSync_in = 1'b0; VSync_in = 1'b0; HBlank_in = 1'b0; VBlank_in = 1'b0;
    pal_we = 1'b0; pal_addr = 5'd0; pal_data = 5'd0; mode_we = 1'b0; mode_data = 2'd0;
    run(2);
    chk_rgb("rst", 0, 0, 0);
    chk("rst_hs", int'(HSync_out), 0);
    reset = 1'b0;

    // First byte_ack lands on the 8th ce_pix after reset release.
    ack_n = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (last_ack && ack_n == 0) ack_n = n;
    end
    chk("first_ack_tick", ack_n, 8);

    // Mode 2, all bytes 0xFF, ink1 bright white.
    pal(1, 'h0B);
    set_mode(2);
    hs_pulse();
    run(14);
    chk_rgb("m2_white", 3, 3, 3);
    cnt_a = 0;
    for (int n = 0; n < 32; n++) begin
      cyc();
      cnt_a += int'(last_ack);
    end
    chk("ack_per_32", cnt_a, 4);

    // Mode 1, byte 0x88, ink3 bright red: 2 red ticks then 6 black per byte.
    pal(3, 'h0C);
    byte_data = 8'h88;
    set_mode(1);
    hs_pulse();
    run(20);
    cnt_a = 0; cnt_b = 0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      if (R_out == 2'd3 && G_out == 2'd0 && B_out == 2'd0) cnt_a++;
      else if (R_out == 2'd0 && G_out == 2'd0 && B_out == 2'd0) cnt_b++;
    end
    chk("m1_red_ticks", cnt_a, 4);
    chk("m1_black_ticks", cnt_b, 12);

    // Mode 0, byte 0x80, ink1 blue: 4 half-blue ticks then 4 black per byte.
    pal(1, 'h04);
    byte_data = 8'h80;
    set_mode(0);
    hs_pulse();
    run(20);
    cnt_a = 0; cnt_b = 0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      if (R_out == 2'd0 && G_out == 2'd0 && B_out == 2'd2) cnt_a++;
      else if (R_out == 2'd0 && G_out == 2'd0 && B_out == 2'd0) cnt_b++;
    end
    chk("m0_blue_ticks", cnt_a, 8);
    chk("m0_black_ticks", cnt_b, 8);

    // Border: de_in low shows ink16 whatever the byte.
    de_in = 1'b0;
    pal(16, 'h12);
    run(3);
    cnt_a = 0;
    for (int n = 0; n < 8; n++) begin
      byte_data = 8'($urandom);
      cyc();
      if (R_out == 2'd0 && G_out == 2'd3 && B_out == 2'd0) cnt_a++;
    end
    chk("border_green_ticks", cnt_a, 8);
    HSync_in = 1'b1; VSync_in = 1'b1;
    cyc();
    chk("hs_delay0", int'(HSync_out), 0);
    HSync_in = 1'b0; VSync_in = 1'b0;
    cyc();
    chk("hs_delay2", int'(HSync_out), 1);
    chk("vs_delay2", int'(VSync_out), 1);
    cyc();
    chk("hs_delay3", int'(HSync_out), 0);

    // Mode write mid-line only takes effect at the next HSync_in rising edge.
    de_in = 1'b1; byte_data = 8'hFF;
    pal(15, 'h0C);
    pal(1, 'h0B);
    set_mode(2);
    hs_pulse();
    run(12);
    set_mode(0);
    run(20);
    chk_rgb("mc_still_m2", 3, 3, 3);
    hs_pulse();
    cyc();
    chk_rgb("mc_old", 3, 3, 3);
    cyc();
    chk_rgb("mc_new", 3, 0, 0);
    ack_n = 0;
    for (int n = 3; n <= 12; n++) begin
      cyc();
      if (last_ack && ack_n == 0) ack_n = n;
    end
    chk("mc_ack_tick", ack_n, 8);

    // Palette write on the same clock as its lookup: old colour, then new.
    pal_we = 1'b1; pal_addr = 5'd15; pal_data = 5'h0B;
    cyc();
    pal_we = 1'b0;
    chk_rgb("pw_old", 3, 0, 0);
    cyc();
    chk_rgb("pw_new", 3, 3, 3);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      ce_pix = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) de_in = ~de_in;
      if ($urandom_range(0, 24) == 0) HSync_in = ~HSync_in;
      if ($urandom_range(0, 40) == 0) VSync_in = ~VSync_in;
      if ($urandom_range(0, 20) == 0) HBlank_in = ~HBlank_in;
      if ($urandom_range(0, 30) == 0) VBlank_in = ~VBlank_in;
      byte_data = 8'($urandom);
      pal_we    = ($urandom_range(0, 7) == 0);
      pal_addr  = 5'($urandom);
      pal_data  = 5'($urandom);
      mode_we   = ($urandom_range(0, 29) == 0);
      mode_data = 2'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cpc_pixel_gen.md
Name: cpc_pixel_gen

Overview:
- Gate-array pixel stage of the CPC video path: serialises video-RAM bytes into pens per screen mode (0-3), maps pens through a 17-entry palette (16 inks + border) to hardware colours, and emits 2-bit R/G/B plus delayed sync/blank.
- Sits directly upstream of the colour-mix/mono stage, which consumes its R/G/B, sync and blank outputs on the same clk_vid/ce_pix.

Parameters:
- DEFAULT_MODE, 1, screen mode loaded at reset.
- HALF_LEVEL, 2, 2-bit code emitted for a 50% gun level; off = 0, full = 3.

Ports:
- clk_vid  in  1  video clock.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  16 MHz-rate pixel enable; all pipeline state advances only when high.
- byte_data  in  8  video-RAM byte, valid while byte_ack is pending.
- byte_ack  out  1  one-clk pulse when byte_data is consumed; upstream advances its address on this pulse.
- de_in  in  1  display enable from the CRTC.
- HSync_in, VSync_in, HBlank_in, VBlank_in  in  1 each  raw timing.
- pal_we  in  1  palette write strobe, any clk.
- pal_addr  in  5  0-15 ink, 16 border; 17-31 ignored.
- pal_data  in  5  hardware colour 0x00-0x1F.
- mode_we  in  1  mode write strobe.
- mode_data  in  2  requested mode.
- R_out, G_out, B_out  out  2 each  gun levels.
- HSync_out, VSync_out, HBlank_out, VBlank_out  out  1 each  timing aligned to R/G/B.

Behaviour:
- Reset:
  - all outputs 0;
  - palette entries = 0x14 (black);
  - mode = pending mode = DEFAULT_MODE;
  - phase = 0;
  - shift register = 0.
- Phase counter: 3 bits, increments on ce_pix, wraps 7->0. Forced to 0 on the ce_pix where HSync_in is 1 and the previous sampled HSync_in was 0.
- Byte load: on the ce_pix with phase==7, byte_data is latched into the shift register and byte_ack pulses for that clk. Pixels from that byte start at phase 0, so one byte always spans 8 ce_pix in every mode.
- Pen decode (combinational, from the shift register and the pixel index within the byte):
  - mode 2: 8 px of 1 ce_pix; pen = bit7, shift left by 1.
  - mode 1: 4 px of 2 ce_pix; pen = {b3,b7}, shift by 1 every 2 ticks.
  - mode 0: 2 px of 4 ce_pix; pen = {b1,b5,b3,b7}, shift by 1 every 4 ticks.
  - mode 3: as mode 0 timing, pen = {b3,b7} (inks 0-3 only).
- Border: when the stage-1 delayed de_in is 0, pen = 16 regardless of data.
- Pipeline:
  - stage 1 registers the pen and the delayed timing;
  - stage 2 looks up the palette, converts through the hardware-colour LUT, and registers R/G/B and timing.
  - Latency from de_in/syncs to outputs is 2 ce_pix. Timing outputs are delayed identically to R/G/B.
- Palette write:
  - takes effect on the clk after pal_we;
  - stage-2 lookup on the same clk as the write uses the old value.
  - pal_addr > 16 is ignored.
- Mode change: mode_we stores pending mode; the active mode updates only at the HSync_in rising-edge ce_pix (same tick phase resets), never mid-line. A later mode_we before the edge overwrites the pending mode.
- Colour LUT levels: 0 -> 0, 1 -> HALF_LEVEL, 2 -> 3. Examples:
  - 0x14 black (0,0,0);
  - 0x04 blue (0,0,H);
  - 0x15 bright blue (0,0,3);
  - 0x1C red (H,0,0);
  - 0x0C bright red (3,0,0);
  - 0x12 bright green (0,3,0);
  - 0x00 white (H,H,H);
  - 0x0B bright white (3,3,3).
- ce_pix low: all state holds, byte_ack stays 0.
- Reset mid-line: immediate return to reset values; the first byte_ack comes 8 ce_pix after reset release.

Decomposition:
- cpc_video_pkg:
  - mode enum (MODE0..MODE3);
  - BORDER_PEN = 16;
  - 32-entry hardware-colour-to-{R,G,B} level table (0/1/2 per gun);
  - level-to-2-bit function.
- One combinational sub-module, cpc_pen_decode: takes shift byte, mode and pixel sub-index; returns the 4-bit pen.

Test Plan:
- Reset, de_in=1, all bytes 0xFF, mode 2, ink1=0x0B -> after 2 ce_pix R/G/B=3,3,3; byte_ack every 8 ce_pix.
- Mode 1, byte 0x88, ink3=0x0C, ink0=0x14 -> first 2 px (3,0,0), remaining 6 ticks (0,0,0).
- Mode 0, byte 0x80, ink1=0x04, HALF_LEVEL=2 -> 4 ticks (0,0,2) then 4 ticks black.
- de_in=0, border=0x12 -> (0,3,0) regardless of byte_data; syncs delayed exactly 2 ce_pix.
- mode_we=0 mid-line while mode 2 is active -> remaining line decodes mode 2; mode 0 from the tick of the HSync_in rising edge; phase resets there.
- pal_we to ink1 on the same clk as the stage-2 lookup of ink1 -> old colour for that pixel, new colour from the next ce_pix.
